pmod1553_phy_io: RTL

//  Multi-channel pin-level front end for PMOD 1553 transceivers between board pins and 1553 encoder/decoder cores.
//  Per channel: synchronises RX pair (PMOD pins 1/2) and sequences transmitter enable (pin 5) around the TX pair (pins 3/4).

---
 rtl/pmod1553_phy_io_if.sv | 23 ++
 rtl/pmod1553_phy_io.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pmod1553_phy_io_if.sv
// Core-side bundle between pmod1553_phy_io and the 1553 encoder/decoder.
// master = encoder/decoder side, slave = PHY side.
interface pmod1553_phy_io_if #(
    parameter int CHANNELS = 1
);
    logic [CHANNELS-1:0] rx_p;
    logic [CHANNELS-1:0] rx_n;
    logic [CHANNELS-1:0] tx_req;
    logic [CHANNELS-1:0] tx_p;
    logic [CHANNELS-1:0] tx_n;
    logic [CHANNELS-1:0] tx_ready;
    logic [CHANNELS-1:0] tx_err;

    modport master (
        input  rx_p, rx_n, tx_ready, tx_err,
        output tx_req, tx_p, tx_n
    );

    modport slave (
        output rx_p, rx_n, tx_ready, tx_err,
        input  tx_req, tx_p, tx_n
    );
endinterface

// File: rtl/pmod1553_phy_io.sv
// Multi-channel PMOD 1553 pin front end: RX sync, TX enable sequencing, LED.
// Define PMOD1553_LOOPBACK_EN to add the per-channel loopback input.
module pmod1553_phy_io #(
    parameter int CHANNELS        = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int TX_GUARD_CYCLES = 100,
    parameter int LED_HOLD_CYCLES = 2**22
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [CHANNELS-1:0] pmod_rx_p_i,
    input  logic [CHANNELS-1:0] pmod_rx_n_i,
    output logic [CHANNELS-1:0] pmod_tx_p_o,
    output logic [CHANNELS-1:0] pmod_tx_n_o,
    output logic [CHANNELS-1:0] pmod_tx_en_o,
`ifdef PMOD1553_LOOPBACK_EN
    input  logic [CHANNELS-1:0] loopback,
`endif
    output logic [CHANNELS-1:0] act_led,
    pmod1553_phy_io_if.slave    core
);
    localparam int GW = $clog2(TX_GUARD_CYCLES + 1);
    localparam int LW = $clog2(LED_HOLD_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(TX_GUARD_CYCLES - 1);
    localparam logic [LW-1:0] LED_RELOAD = LW'(LED_HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ENABLE,
        ACTIVE,
        DRAIN
    } state_e;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_e                 st_q;
        logic [GW-1:0]          gcnt_q;
        logic                   en_q;
        logic                   txp_q;
        logic                   txn_q;
        logic                   rdy_q;
        logic                   err_q;
        logic [SYNC_STAGES-1:0] sp_q, sp_d;
        logic [SYNC_STAGES-1:0] sn_q, sn_d;
        logic                   rxp_prev_q;
        logic                   rxn_prev_q;
        logic [LW-1:0]          led_q, led_d;
        logic                   lb;
        logic                   req;
        logic                   ev;

`ifdef PMOD1553_LOOPBACK_EN
        assign lb = loopback[c];
`else
        assign lb = 1'b0;
`endif
        assign req = core.tx_req[c];

        // Loopback feeds the registered TX pair into the same chain as the pins
        assign sp_d = {sp_q[SYNC_STAGES-2:0], lb ? txp_q : pmod_rx_p_i[c]};
        assign sn_d = {sn_q[SYNC_STAGES-2:0], lb ? txn_q : pmod_rx_n_i[c]};

        always_ff @(posedge clk) begin
            if (!resetn) begin
                sp_q       <= '0;
                sn_q       <= '0;
                rxp_prev_q <= 1'b0;
                rxn_prev_q <= 1'b0;
            end else begin
                sp_q       <= sp_d;
                sn_q       <= sn_d;
                rxp_prev_q <= sp_q[SYNC_STAGES-1];
                rxn_prev_q <= sn_q[SYNC_STAGES-1];
            end
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                st_q   <= IDLE;
                gcnt_q <= '0;
                en_q   <= 1'b0;
                txp_q  <= 1'b0;
                txn_q  <= 1'b0;
                rdy_q  <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                err_q <= 1'b0;
                txp_q <= 1'b0;
                txn_q <= 1'b0;
                en_q  <= ~lb & (st_q != IDLE);
                unique case (st_q)
                    IDLE: begin
                        if (req) begin
                            st_q   <= ENABLE;
                            gcnt_q <= '0;
                            en_q   <= ~lb;
                        end
                    end
                    ENABLE: begin
                        if (!req) begin
                            st_q   <= DRAIN;
                            gcnt_q <= '0;
                        end else if (gcnt_q == GUARD_LAST) begin
                            st_q  <= ACTIVE;
                            rdy_q <= 1'b1;
                        end else begin
                            gcnt_q <= gcnt_q + 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (!req) begin
                            st_q   <= DRAIN;
                            gcnt_q <= '0;
                            rdy_q  <= 1'b0;
                        end else begin
                            // Both lines high is illegal: idle the pair, flag it
                            err_q <= core.tx_p[c] & core.tx_n[c];
                            txp_q <= core.tx_p[c] & ~core.tx_n[c];
                            txn_q <= core.tx_n[c] & ~core.tx_p[c];
                        end
                    end
                    DRAIN: begin
                        if (gcnt_q == GUARD_LAST) begin
                            st_q <= IDLE;
                            en_q <= 1'b0;
                        end else begin
                            gcnt_q <= gcnt_q + 1'b1;
                        end
                    end
                    default: st_q <= IDLE;
                endcase
            end
        end

        assign ev = (sp_q[SYNC_STAGES-1] ^ rxp_prev_q)
                  | (sn_q[SYNC_STAGES-1] ^ rxn_prev_q)
                  | (st_q == ACTIVE);

        always_comb begin
            led_d = led_q;
            if (ev) begin
                led_d = LED_RELOAD;
            end else if (led_q != '0) begin
                led_d = led_q - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                led_q <= '0;
            end else begin
                led_q <= led_d;
            end
        end

        assign pmod_tx_p_o[c]  = txp_q;
        assign pmod_tx_n_o[c]  = txn_q;
        assign pmod_tx_en_o[c] = en_q;
        assign core.rx_p[c]     = sp_q[SYNC_STAGES-1];
        assign core.rx_n[c]     = sn_q[SYNC_STAGES-1];
        assign core.tx_ready[c] = rdy_q;
        assign core.tx_err[c]   = err_q;
        assign act_led[c]       = (led_q != '0);
    end
endmodule
